// File: rtl/parity_pkg.sv
// Shared definitions for the parity serializer and the downstream parity tracker.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_serializer.sv
// Serializes a parallel word LSB-first after a valid/ready handshake and closes
// each frame with a single parity bit flagged by ser_last.
module parity_serializer
   import parity_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit ODD   = PARITY_EVEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_last_q, ser_last_d;
   logic             accept;

   // The PARITY cycle can take the next word, so frames run back to back.
   assign in_ready = (state_q != DATA);
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DATA;
               shift_d = in_data;
               cnt_d   = '0;
               par_d   = (^in_data) ^ ODD;
            end
         end
         DATA: begin
            shift_d = shift_q >> 1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = PARITY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (accept) begin
               state_d = DATA;
               shift_d = in_data;
               cnt_d   = '0;
               par_d   = (^in_data) ^ ODD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next-state values.
      ser_valid_d = (state_d != IDLE);
      ser_last_d  = (state_d == PARITY);
      ser_out_d   = 1'b0;
      if (state_d == DATA) begin
         ser_out_d = shift_d[0];
      end else if (state_d == PARITY) begin
         ser_out_d = par_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         par_q       <= par_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Self-checking bench: even and odd parity instances share stimulus and are
// compared each cycle against a queue-of-pending-bits reference model.
module tb_parity_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic rdy0, so0, sv0, sl0, b0;
   logic rdy1, so1, sv1, sl1, b1;

   int n_vec = 0;
   int n_bad = 0;

   // Each entry is {last, bit}; head of the queue is what the DUT shows now.
   logic [1:0] q0[$];
   logic [1:0] q1[$];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [4:0] exp;  // {ser_valid, ser_out, ser_last, busy, in_ready}
   } vec_t;

   vec_t tbl[11];

   always #5 clk = ~clk;

   parity_serializer #(.WIDTH(8), .ODD(1'b0)) u_even (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0), .busy(b0)
   );

   parity_serializer #(.WIDTH(8), .ODD(1'b1)) u_odd (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1), .busy(b1)
   );

   function automatic logic [4:0] model_exp(input logic [1:0] head, input int sz);
      logic ne;
      ne = (sz > 0);
      return {ne, ne & head[0], ne & head[1], ne, (sz <= 1)};
   endfunction

   task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
      logic ok0, ok1;
      ok0 = (q0.size() <= 1);
      ok1 = (q1.size() <= 1);
      if (r) begin
         q0.delete();
         q1.delete();
      end else begin
         if (q0.size() > 0) void'(q0.pop_front());
         if (q1.size() > 0) void'(q1.pop_front());
         if (v && ok0) begin
            for (int i = 0; i < 8; i++) q0.push_back({1'b0, d[i]});
            q0.push_back({1'b1, ^d});
         end
         if (v && ok1) begin
            for (int i = 0; i < 8; i++) q1.push_back({1'b0, d[i]});
            q1.push_back({1'b1, ~(^d)});
         end
      end
   endtask

   // One clock: drive inputs, check both instances against the model, advance.
   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       output logic [4:0] o0, output logic [4:0] o1);
      logic [1:0] h0, h1;
      @(negedge clk);
      reset    = r;
      in_valid = v;
      in_data  = d;
      #1;
      o0 = {sv0, so0, sl0, b0, rdy0};
      o1 = {sv1, so1, sl1, b1, rdy1};
      h0 = (q0.size() > 0) ? q0[0] : 2'b00;
      h1 = (q1.size() > 0) ? q1[0] : 2'b00;
      chk("model_even", o0, model_exp(h0, q0.size()));
      chk("model_odd", o1, model_exp(h1, q1.size()));
      @(posedge clk);
      model_edge(r, v, d);
   endtask

   initial begin
      logic [4:0] o0, o1;
      logic [7:0] a5;
      int         run;
      int         lp;

      a5 = 8'hA5;
      tbl[0] = '{1'b1, 8'hA5, 5'b00001};
      for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 8'h00, {1'b1, a5[i-1], 1'b0, 1'b1, 1'b0}};
      tbl[9]  = '{1'b0, 8'h00, 5'b10111};
      tbl[10] = '{1'b0, 8'h00, 5'b00001};

      repeat (2) @(posedge clk);

      // Reset state, then the 0xA5 frame from the table.
      for (int i = 0; i < 11; i++) begin
         step(1'b0, tbl[i].v, tbl[i].d, o0, o1);
         chk("table_a5", o0, tbl[i].exp);
      end

      // Parity of 0x07 and 0x00 on both instances.
      step(1'b0, 1'b1, 8'h07, o0, o1);
      for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 8'h00, o0, o1);
      chk_i("par07_even", int'(o0[3]), 1);
      chk_i("par07_odd", int'(o1[3]), 0);
      step(1'b0, 1'b1, 8'h00, o0, o1);
      for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 8'h00, o0, o1);
      chk_i("par00_even", int'(o0[3]), 0);
      chk_i("par00_odd", int'(o1[3]), 1);
      step(1'b0, 1'b0, 8'h00, o0, o1);

      // Back-to-back frames with in_valid held high.
      step(1'b0, 1'b1, 8'h01, o0, o1);
      run = 0;
      lp  = 0;
      for (int c = 0; c < 18; c++) begin
         step(1'b0, (c < 9), 8'h03, o0, o1);
         if (o0[4]) run++;
         if (o0[2]) lp |= (1 << c);
      end
      chk_i("b2b_valid_run", run, 18);
      chk_i("b2b_last_mask", lp, (1 << 8) | (1 << 17));
      step(1'b0, 1'b0, 8'h00, o0, o1);

      // Changing in_data while in DATA is ignored; next word taken in PARITY.
      step(1'b0, 1'b1, 8'h3C, o0, o1);
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 8'($urandom), o0, o1);
      step(1'b0, 1'b1, 8'hC3, o0, o1);
      for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 8'h00, o0, o1);
      step(1'b0, 1'b0, 8'h00, o0, o1);

      // Reset in the cycle presenting bit 3 of 0xFF, then a clean 0x0F frame.
      step(1'b0, 1'b1, 8'hFF, o0, o1);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 8'h00, o0, o1);
      step(1'b1, 1'b0, 8'h00, o0, o1);
      step(1'b0, 1'b1, 8'h0F, o0, o1);
      chk("abort_idle", o0, 5'b00001);
      for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 8'h00, o0, o1);
      chk("par0f_even", o0, 5'b10111);
      step(1'b0, 1'b0, 8'h00, o0, o1);

      // Reset wins over an offer in IDLE.
      step(1'b1, 1'b1, 8'h5A, o0, o1);
      step(1'b0, 1'b0, 8'h00, o0, o1);
      chk("reset_drop", o0, 5'b00001);
      step(1'b0, 1'b0, 8'h00, o0, o1);
      chk("reset_drop2", o0, 5'b00001);

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
              8'($urandom), o0, o1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/parity_serializer.md
# parity_serializer

Upstream feeder for the serial parity tracker. Accepts a parallel word through a valid/ready handshake and emits it LSB-first, one bit per clock, then appends one parity bit that closes the frame. Downstream consumers take `ser_out` as their serial input. They use `ser_valid` and `ser_last` to delimit frames and clear their running parity between frames.

## Interface

Parameters:

- `WIDTH`, default 8: data bits per frame; legal range ≥ 2.
- `ODD`, default 0: 0 selects even parity, 1 selects odd parity.

Ports:

- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_data`, input, WIDTH: parallel word to serialize.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the block can accept a word this cycle.
- `ser_out`, output, 1: serial bit stream.
- `ser_valid`, output, 1: `ser_out` carries a frame bit (data or parity).
- `ser_last`, output, 1: `ser_out` is the parity bit, the final bit of the frame.
- `busy`, output, 1: a frame is in progress (DATA or PARITY state).

## Operation

- States: IDLE, DATA, PARITY.
- **Acceptance**
  - A word is accepted at a rising edge where `in_valid && in_ready`.
  - `in_data` is captured into the shift register at that edge.
  - Later changes to `in_data` have no effect on the frame in progress.
  - `in_ready` is combinational from state: 1 in IDLE and PARITY, 0 in DATA.
- **Transitions**
  - IDLE → DATA on acceptance. IDLE otherwise.
  - DATA → DATA while bit counter < WIDTH−1. DATA → PARITY after bit WIDTH−1 is presented.
  - PARITY → DATA on acceptance, giving back-to-back frames with zero bubble. PARITY → IDLE otherwise.
- **Parity**
  - Value = XOR of all WIDTH captured bits, XOR `ODD`.
  - Computed from the captured word at acceptance and held in a register until the PARITY state.
- **Bit counter**
  - Width is $clog2(WIDTH).
  - Loaded to 0 on acceptance and increments each DATA cycle.
  - Never wraps past WIDTH−1, because the transition to PARITY occurs first.
- **Outputs** (all registered; driven from state, shift register LSB and parity register):
  - DATA: `ser_out` = current bit, `ser_valid` = 1, `ser_last` = 0.
  - PARITY: `ser_out` = parity, `ser_valid` = 1, `ser_last` = 1.
  - IDLE: `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0.
- **Reset**
  - Values: state = IDLE, counter = 0, shift register = 0, parity register = 0.
  - Resulting outputs: `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0, `busy` = 0, `in_ready` = 1.
  - Reset mid-frame aborts the frame. No parity bit is emitted, and the next cycle is IDLE.
  - Reset has priority over acceptance in the same cycle; the offered word is dropped.
- `in_valid` asserted during DATA is ignored, because `in_ready` = 0 and no capture occurs.

## Timing

- Acceptance at edge T gives:
  - data bit i on `ser_out` during cycle T+1+i, for i = 0..WIDTH−1;
  - the parity bit during cycle T+WIDTH+1.
- Latency from acceptance to first serial bit: 1 cycle.
- Sustained throughput: one word per WIDTH+1 cycles when `in_valid` is held high.
- `ser_valid` is continuous across back-to-back frames. `ser_last` pulses for exactly one cycle per frame.
- No downstream backpressure: the downstream stage consumes one bit per cycle whenever `ser_valid` = 1.

## Structure

- Shared package `parity_pkg` holds:
  - the state enum `ser_state_t` (IDLE, DATA, PARITY);
  - constants `PARITY_EVEN` = 0 and `PARITY_ODD` = 1.
- The downstream parity tracker imports `parity_pkg` for the same constants.
- Single flat module with no sub-module. The shift register, counter and parity register are small enough to stay inline.

## Test plan

- WIDTH=8, ODD=0, accept 0xA5:
  - `ser_out` = 1,0,1,0,0,1,0,1 over cycles T+1..T+8 with `ser_valid` = 1;
  - then parity 0 with `ser_last` = 1 at T+9;
  - then IDLE with `ser_valid` = 0.
- WIDTH=8, ODD=0, accept 0x07 → parity bit 1. Same word with ODD=1 → parity bit 0. ODD=1, accept 0x00 → parity bit 1.
- Back-to-back frames: `in_valid` held high with 0x01 then 0x03 offered.
  - The second word is accepted in the PARITY cycle of the first.
  - The second frame's bit 0 appears in the immediately following cycle.
  - `ser_valid` stays 1 for 18 consecutive cycles, and `ser_last` pulses at cycles 9 and 18.
- `in_valid` = 1 with a changing `in_data` during DATA:
  - `in_ready` = 0 and the captured frame is unaffected;
  - the next word is accepted only in the PARITY cycle.
- Reset asserted at the cycle presenting data bit 3 of 0xFF:
  - next cycle all outputs are 0 and `in_ready` = 1;
  - no parity bit is emitted;
  - a following accept of 0x0F produces a clean frame with parity 0.
- Reset and `in_valid` both high in IDLE → word dropped, `ser_valid` stays 0.
